// File: rtl/lz4_wbuf_pkg.sv
// lz4_wbuf_pkg: shared types and helpers for the LZ4 compress-path window buffer.
//   - wbuf_state_e : top-level sequencing state (IDLE, RUN, FLUSH)
//   - bpw_f        : bytes per storage word
//   - cnt_w_f      : width of a byte-count field that can hold 0..BPW
//   - left_mask_f  : n ones left-aligned in a bpw-bit byte mask (MSB = first byte)
//   - byte_span_f  : bpw bytes starting at byte offset 'off' of the pair {lo, hi}
// Helpers work on MAX_DATA_W-wide containers; callers cast to their own width.
package lz4_wbuf_pkg;

    localparam int unsigned MAX_DATA_W = 256;
    localparam int unsigned MAX_BPW    = MAX_DATA_W / 8;
    localparam int unsigned PAIR_W     = 2 * MAX_DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } wbuf_state_e;

    function automatic int unsigned bpw_f(input int unsigned data_w);
        return data_w / 8;
    endfunction

    function automatic int unsigned cnt_w_f(input int unsigned data_w);
        return $clog2(data_w / 8) + 1;
    endfunction

    function automatic logic [MAX_BPW-1:0] left_mask_f(input int unsigned n,
                                                       input int unsigned bpw);
        logic [MAX_BPW-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_BPW; i++) begin
            if (i < bpw && i < n) begin
                m[bpw-1-i] = 1'b1;
            end
        end
        return m;
    endfunction

    // lo holds the earlier word, hi the following one; both right-aligned.
    function automatic logic [MAX_DATA_W-1:0] byte_span_f(input logic [MAX_DATA_W-1:0] lo,
                                                          input logic [MAX_DATA_W-1:0] hi,
                                                          input int unsigned bpw,
                                                          input int unsigned off);
        logic [PAIR_W-1:0] pair;
        pair = (PAIR_W'(lo) << (bpw * 8)) | PAIR_W'(hi);
        return MAX_DATA_W'((pair << (off * 8)) >> (bpw * 8));
    endfunction

endpackage

// File: rtl/lz4_window_buffer_bank.sv
// lz4_wbuf_bank: one half (even or odd words) of the window storage.
//   clk, rst            : clock, synchronous active-high reset (read registers only)
//   we_i/waddr_i/wdata_i: single write port
//   h_addr_i/h_data_o   : head read port, registered, reads every cycle
//   r_en_i/r_addr_i/r_data_o : history read port, registered, holds when idle
// A read of the address being written in the same cycle returns the new data.
module lz4_wbuf_bank
    import lz4_wbuf_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned AW     = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     h_addr_i,
    output logic [DATA_W-1:0] h_data_o,
    input  logic              r_en_i,
    input  logic [AW-1:0]     r_addr_i,
    output logic [DATA_W-1:0] r_data_o
);

    localparam int unsigned ENTRIES = 2 ** AW;

    logic [DATA_W-1:0] mem [ENTRIES];
    logic [DATA_W-1:0] h_data_q;
    logic [DATA_W-1:0] r_data_q;

    // Storage array: contents are not cleared on reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Registered read ports with write-through bypass.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_data_q <= '0;
            r_data_q <= '0;
        end else begin
            h_data_q <= (we_i && (waddr_i == h_addr_i)) ? wdata_i : mem[h_addr_i];
            if (r_en_i) begin
                r_data_q <= (we_i && (waddr_i == r_addr_i)) ? wdata_i : mem[r_addr_i];
            end
        end
    end

    assign h_data_o = h_data_q;
    assign r_data_o = r_data_q;

endmodule

// File: rtl/lz4_window_buffer.sv
// lz4_window_buffer: circular dictionary buffer for the LZ4 compress path.
// Holds the input stream in even/odd word banks so any unaligned BPW-byte
// span is read in one access. Addresses are absolute 32-bit stream offsets.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   start, finish            : begin stream (RUN) / end stream (FLUSH)
//   last_bytes               : valid bytes in a word written together with finish
//   wr_req, wr_data, wr_ready: word write port with back-pressure
//   adv_valid, adv_bytes     : head advance (clamped to written end)
//   head_abs/_data/_mask     : lookahead view at the compressor head
//   hist_rd/_addr -> hist_valid/_data/_mask/_oor : 1-cycle history read
//   level                    : words held between window floor and write pointer
//   done                     : pulse when FLUSH drains; err : sticky protocol error
// Build option: define LZ4_WBUF_ERR_EN to enable the err detector (else err = 0).
// DATA_W must be a power-of-two multiple of 16 bits, ADDR_W >= 2.
module lz4_window_buffer
    import lz4_wbuf_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned WIN_BYTES = 49152
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          finish,
    input  logic [cnt_w_f(DATA_W)-1:0]    last_bytes,
    input  logic                          wr_req,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_ready,
    input  logic                          adv_valid,
    input  logic [cnt_w_f(DATA_W)-1:0]    adv_bytes,
    output logic [31:0]                   head_abs,
    output logic [DATA_W-1:0]             head_data,
    output logic [bpw_f(DATA_W)-1:0]      head_mask,
    input  logic                          hist_rd,
    input  logic [31:0]                   hist_addr,
    output logic                          hist_valid,
    output logic [DATA_W-1:0]             hist_data,
    output logic [bpw_f(DATA_W)-1:0]      hist_mask,
    output logic                          hist_oor,
    output logic [ADDR_W:0]               level,
    output logic                          done,
    output logic                          err
);

    localparam int unsigned BPW     = bpw_f(DATA_W);
    localparam int unsigned BO      = $clog2(BPW);
    localparam int unsigned DEPTH   = 2 ** ADDR_W;
    localparam int unsigned BANK_AW = ADDR_W - 1;
    localparam int unsigned LVL_W   = ADDR_W + 1;
    localparam logic [31:0] CAP_BYTES  = 32'(DEPTH * BPW);
    localparam logic [31:0] WIN        = 32'(WIN_BYTES);
    localparam logic [31:0] BPW32      = 32'(BPW);
    localparam logic [31:0] ALIGN_MASK = ~(BPW32 - 32'd1);

    // Byte mask for min(BPW, avail) valid bytes.
    function automatic logic [BPW-1:0] span_mask_f(input logic [31:0] avail);
        int unsigned n;
        n = (avail > BPW32) ? BPW : avail;
        return BPW'(left_mask_f(n, BPW));
    endfunction

    wbuf_state_e          state_q, state_d;
    logic [31:0]          wr_abs_q, wr_abs_d;
    logic [31:0]          head_abs_q, head_abs_d;
    logic [31:0]          floor_q, floor_d;
    logic                 wr_ready_q, wr_ready_d;
    logic [BPW-1:0]       head_mask_q, head_mask_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 done_q, done_d;
    logic                 hist_valid_q;
    logic [BPW-1:0]       hist_mask_q;
    logic                 hist_oor_q;
    logic                 head_sel_q, hist_sel_q;
    logic [BO-1:0]        head_off_q, hist_off_q;

    logic                 space_c;
    logic                 wr_acc_c;
    logic [31:0]          lb32_c;
    logic [31:0]          adv32_c;
    logic                 adv_over_c;
    logic                 hist_oor_c;
    logic [BPW-1:0]       hist_mask_c;
    logic [31:0]          fill_c;

    logic [ADDR_W-1:0]    wr_word_c, hw0_c, rw0_c;
    logic [BANK_AW-1:0]   wr_bank_addr_c;
    logic [BANK_AW-1:0]   h_even_addr_c, h_odd_addr_c, r_even_addr_c, r_odd_addr_c;
    logic [DATA_W-1:0]    even_h, odd_h, even_r, odd_r;
    logic [DATA_W-1:0]    head_lo_c, head_hi_c, hist_lo_c, hist_hi_c;

    // Write acceptance: a finish word only needs free space outside IDLE.
    always_comb begin
        lb32_c   = (32'(last_bytes) > BPW32) ? BPW32 : 32'(last_bytes);
        space_c  = (wr_abs_q - floor_q) < CAP_BYTES;
        wr_acc_c = 1'b0;
        if (wr_req) begin
            if (finish) begin
                wr_acc_c = (state_q != ST_IDLE) && space_c && (lb32_c != 32'd0);
            end else begin
                wr_acc_c = wr_ready_q;
            end
        end
        adv32_c    = adv_valid ? 32'(adv_bytes) : 32'd0;
        adv_over_c = adv32_c > (wr_abs_q - head_abs_q);
    end

    // Next-state, counters and registered-output next values.
    always_comb begin
        state_d    = state_q;
        done_d     = 1'b0;
        wr_abs_d   = wr_abs_q;
        head_abs_d = adv_over_c ? wr_abs_q : (head_abs_q + adv32_c);
        if (wr_acc_c) begin
            wr_abs_d = wr_abs_q + (finish ? lb32_c : BPW32);
        end

        case (state_q)
            ST_IDLE:  state_d = ST_IDLE;
            ST_RUN:   if (finish) state_d = ST_FLUSH;
            ST_FLUSH: begin
                if (head_abs_d == wr_abs_d) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default:  state_d = ST_IDLE;
        endcase

        if (start) begin
            state_d    = ST_RUN;
            done_d     = 1'b0;
            wr_abs_d   = '0;
            head_abs_d = '0;
        end

        floor_d     = (head_abs_d >= WIN) ? ((head_abs_d - WIN) & ALIGN_MASK) : 32'd0;
        fill_c      = wr_abs_d - floor_d;
        wr_ready_d  = (state_d == ST_RUN) && (fill_c < CAP_BYTES);
        level_d     = LVL_W'((fill_c + BPW32 - 32'd1) >> BO);
        head_mask_d = span_mask_f(wr_abs_d - head_abs_d);
    end

    // History range check against the window as it stands this cycle.
    always_comb begin
        hist_oor_c  = (hist_addr < floor_q) || (hist_addr >= wr_abs_q);
        hist_mask_c = hist_oor_c ? '0 : span_mask_f(wr_abs_q - hist_addr);
    end

    // Bank addressing: word w lives in bank w[0] at row w>>1; an unaligned
    // span starting in word w also needs word w+1, whose even row is (w+1)>>1.
    always_comb begin
        wr_word_c      = wr_abs_q[BO +: ADDR_W];
        wr_bank_addr_c = wr_word_c[ADDR_W-1:1];
        hw0_c          = head_abs_d[BO +: ADDR_W];
        h_odd_addr_c   = hw0_c[ADDR_W-1:1];
        h_even_addr_c  = hw0_c[ADDR_W-1:1] + BANK_AW'(hw0_c[0]);
        rw0_c          = hist_addr[BO +: ADDR_W];
        r_odd_addr_c   = rw0_c[ADDR_W-1:1];
        r_even_addr_c  = rw0_c[ADDR_W-1:1] + BANK_AW'(rw0_c[0]);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_abs_q     <= '0;
            head_abs_q   <= '0;
            floor_q      <= '0;
            wr_ready_q   <= 1'b0;
            head_mask_q  <= '0;
            level_q      <= '0;
            done_q       <= 1'b0;
            hist_valid_q <= 1'b0;
            hist_mask_q  <= '0;
            hist_oor_q   <= 1'b0;
            head_sel_q   <= 1'b0;
            head_off_q   <= '0;
            hist_sel_q   <= 1'b0;
            hist_off_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_abs_q     <= wr_abs_d;
            head_abs_q   <= head_abs_d;
            floor_q      <= floor_d;
            wr_ready_q   <= wr_ready_d;
            head_mask_q  <= head_mask_d;
            level_q      <= level_d;
            done_q       <= done_d;
            head_sel_q   <= hw0_c[0];
            head_off_q   <= head_abs_d[BO-1:0];
            hist_valid_q <= hist_rd;
            if (hist_rd) begin
                hist_mask_q <= hist_mask_c;
                hist_oor_q  <= hist_oor_c;
                hist_sel_q  <= rw0_c[0];
                hist_off_q  <= hist_addr[BO-1:0];
            end
        end
    end

`ifdef LZ4_WBUF_ERR_EN
    logic err_q;

    // Sticky protocol error: dropped write, over-advance, out-of-window read.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            err_q <= 1'b0;
        end else if ((wr_req && !wr_acc_c) || (adv_valid && adv_over_c) ||
                     (hist_rd && hist_oor_c)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    lz4_wbuf_bank #(.DATA_W(DATA_W), .AW(BANK_AW)) u_bank_even (
        .clk      (clk),
        .rst      (rst),
        .we_i     (wr_acc_c && !wr_word_c[0]),
        .waddr_i  (wr_bank_addr_c),
        .wdata_i  (wr_data),
        .h_addr_i (h_even_addr_c),
        .h_data_o (even_h),
        .r_en_i   (hist_rd),
        .r_addr_i (r_even_addr_c),
        .r_data_o (even_r)
    );

    lz4_wbuf_bank #(.DATA_W(DATA_W), .AW(BANK_AW)) u_bank_odd (
        .clk      (clk),
        .rst      (rst),
        .we_i     (wr_acc_c && wr_word_c[0]),
        .waddr_i  (wr_bank_addr_c),
        .wdata_i  (wr_data),
        .h_addr_i (h_odd_addr_c),
        .h_data_o (odd_h),
        .r_en_i   (hist_rd),
        .r_addr_i (r_odd_addr_c),
        .r_data_o (odd_r)
    );

    // Order the two bank words so the span's first word comes first.
    always_comb begin
        head_lo_c = head_sel_q ? odd_h  : even_h;
        head_hi_c = head_sel_q ? even_h : odd_h;
        hist_lo_c = hist_sel_q ? odd_r  : even_r;
        hist_hi_c = hist_sel_q ? even_r : odd_r;
    end

    assign head_data  = DATA_W'(byte_span_f(MAX_DATA_W'(head_lo_c), MAX_DATA_W'(head_hi_c),
                                            BPW, 32'(head_off_q)));
    assign hist_data  = DATA_W'(byte_span_f(MAX_DATA_W'(hist_lo_c), MAX_DATA_W'(hist_hi_c),
                                            BPW, 32'(hist_off_q)));
    assign wr_ready   = wr_ready_q;
    assign head_abs   = head_abs_q;
    assign head_mask  = head_mask_q;
    assign hist_valid = hist_valid_q;
    assign hist_mask  = hist_mask_q;
    assign hist_oor   = hist_oor_q;
    assign level      = level_q;
    assign done       = done_q;

endmodule

// File: tb/tb_lz4_window_buffer.sv
// Directed bench for lz4_window_buffer with DATA_W=32, ADDR_W=4, WIN_BYTES=48.
module tb_lz4_window_buffer;

    logic        clk = 1'b0;
    logic        rst, start, finish, wr_req, adv_valid, hist_rd;
    logic [2:0]  last_bytes, adv_bytes;
    logic [31:0] wr_data, hist_addr;
    logic        wr_ready, hist_valid, hist_oor, done, err;
    logic [31:0] head_abs, head_data, hist_data;
    logic [3:0]  head_mask, hist_mask;
    logic [4:0]  level;

    int checks = 0;
    int errors = 0;

`ifdef LZ4_WBUF_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    lz4_window_buffer #(.DATA_W(32), .ADDR_W(4), .WIN_BYTES(48)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .finish     (finish),
        .last_bytes (last_bytes),
        .wr_req     (wr_req),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .adv_valid  (adv_valid),
        .adv_bytes  (adv_bytes),
        .head_abs   (head_abs),
        .head_data  (head_data),
        .head_mask  (head_mask),
        .hist_rd    (hist_rd),
        .hist_addr  (hist_addr),
        .hist_valid (hist_valid),
        .hist_data  (hist_data),
        .hist_mask  (hist_mask),
        .hist_oor   (hist_oor),
        .level      (level),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; finish = 1'b0; wr_req = 1'b0; adv_valid = 1'b0;
        hist_rd = 1'b0; last_bytes = '0; adv_bytes = '0; wr_data = '0; hist_addr = '0;

        // Reset held for two cycles
        tick(); tick();
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_head_abs", head_abs, 32'd0);
        check("rst_head_data", head_data, 32'd0);
        check("rst_head_mask", 32'(head_mask), 32'd0);
        check("rst_hist", {hist_valid, hist_oor, hist_mask}, 6'd0);
        check("rst_hist_data", hist_data, 32'd0);
        check("rst_misc", {level, done, err}, 7'd0);
        rst = 1'b0;
        tick();
        check("idle_wr_ready", 32'(wr_ready), 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        check("start_wr_ready", 32'(wr_ready), 32'd1);

        // Lookahead alignment
        wr_req = 1'b1; wr_data = 32'h00010203; tick();
        wr_data = 32'h04050607; tick();
        wr_req = 1'b0;
        check("level_2", 32'(level), 32'd2);
        adv_valid = 1'b1; adv_bytes = 3'd3; tick(); adv_valid = 1'b0;
        check("adv3_head_abs", head_abs, 32'd3);
        check("adv3_head_data", head_data, 32'h03040506);
        check("adv3_head_mask", 32'(head_mask), 32'hF);

        // History reads, back to back
        wr_req = 1'b1; wr_data = 32'h08090A0B; tick(); wr_req = 1'b0;
        hist_rd = 1'b1; hist_addr = 32'd5; tick();
        check("h5_valid", 32'(hist_valid), 32'd1);
        check("h5_data", hist_data, 32'h05060708);
        check("h5_mask", 32'(hist_mask), 32'hF);
        check("h5_oor", 32'(hist_oor), 32'd0);
        hist_addr = 32'd10; tick(); hist_rd = 1'b0;
        check("h10_mask", 32'(hist_mask), 32'hC);
        check("h10_data_hi", 32'(hist_data[31:16]), 32'h0A0B);
        tick();
        check("h_valid_drop", 32'(hist_valid), 32'd0);
        check("err_clean", 32'(err), 32'd0);

        // Full and wrap, from a fresh start
        start = 1'b1; tick(); start = 1'b0;
        check("restart", {head_abs, level, wr_ready}, {32'd0, 5'd0, 1'b1});
        wr_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_data = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
            tick();
        end
        check("full_wr_ready", 32'(wr_ready), 32'd0);
        check("full_level", 32'(level), 32'd16);
        wr_data = 32'hDEADBEEF; tick(); wr_req = 1'b0;
        check("drop_level", 32'(level), 32'd16);
        check("drop_err", 32'(err), 32'(EXP_ERR));
        adv_valid = 1'b1; adv_bytes = 3'd4;
        for (int i = 0; i < 13; i++) tick();
        adv_valid = 1'b0;
        check("h52_head_abs", head_abs, 32'd52);
        check("h52_wr_ready", 32'(wr_ready), 32'd1);
        check("h52_level", 32'(level), 32'd15);
        check("h52_head_data", head_data, 32'h34353637);
        wr_req = 1'b1; wr_data = 32'h40414243; tick(); wr_req = 1'b0;
        check("w17_wr_ready", 32'(wr_ready), 32'd0);
        check("w17_level", 32'(level), 32'd16);
        hist_rd = 1'b1; hist_addr = 32'd64; tick();
        check("h64_data", hist_data, 32'h40414243);
        check("h64_mask", 32'(hist_mask), 32'hF);
        hist_addr = 32'd6; tick();
        check("h6_data", hist_data, 32'h06070809);
        check("h6_oor", 32'(hist_oor), 32'd0);
        hist_addr = 32'd2; tick(); hist_rd = 1'b0;
        check("h2_oor", {hist_oor, hist_mask}, 5'b1_0000);

        // Out of range at head 60 (floor 12)
        adv_valid = 1'b1; adv_bytes = 3'd4; tick(); tick(); adv_valid = 1'b0;
        check("h60_head_abs", head_abs, 32'd60);
        check("h60_wr_ready", 32'(wr_ready), 32'd1);
        hist_rd = 1'b1; hist_addr = 32'd8; tick();
        check("h8_oor", {hist_valid, hist_oor, hist_mask}, 6'b11_0000);
        check("h8_err", 32'(err), 32'(EXP_ERR));
        hist_addr = 32'd12; tick(); hist_rd = 1'b0;
        check("h12_data", hist_data, 32'h0C0D0E0F);
        check("h12_mask", {hist_oor, hist_mask}, 5'b0_1111);

        // Flush with a 2-byte final word
        wr_req = 1'b1; finish = 1'b1; last_bytes = 3'd2; wr_data = 32'hAABB0000; tick();
        wr_req = 1'b0; finish = 1'b0; last_bytes = '0;
        check("fin_wr_ready", 32'(wr_ready), 32'd0);
        check("fin_level", 32'(level), 32'd15);
        check("fin_done", 32'(done), 32'd0);
        adv_valid = 1'b1; adv_bytes = 3'd4; tick(); tick();
        check("h68_head_mask", 32'(head_mask), 32'hC);
        check("h68_head_data_hi", 32'(head_data[31:16]), 32'hAABB);
        check("h68_done", 32'(done), 32'd0);
        tick(); adv_valid = 1'b0;
        check("clamp_head_abs", head_abs, 32'd70);
        check("clamp_done", 32'(done), 32'd1);
        check("clamp_state", {wr_ready, head_mask, level}, {1'b0, 4'd0, 5'd13});
        check("clamp_err", 32'(err), 32'(EXP_ERR));
        tick();
        check("done_pulse", 32'(done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
